// File: rtl/ahb_test_uart_reporter.sv
// ahb_test_uart_reporter
//
// Watches the AHB-Lite test master's status outputs and, on each report
// event, snapshots them and sends a fixed 19-character ASCII line over an
// 8N1 UART:  "C=hh E=hhhhhhhh s\r\n"  (uppercase hex, s = status char).
//
// Ports
//   HCLK       in   clock, all logic on the rising edge
//   HRESET     in   synchronous active-high reset
//   ERRCOUNT   in   [31:0] cumulative error count from the test master
//   CHKCOUNT   in   [7:0]  completed-check-pass count from the test master
//   S_WRITE    in   master in write phase
//   S_CHECK    in   master in check phase
//   S_SUCCESS  in   master finished, no errors
//   S_FAILED   in   master finished, errors found
//   UART_TX    out  serial line, idle high (registered, glitch-free)
//   BUSY       out  high while a frame is on the line
//   FRAME_CNT  out  [15:0] number of fully sent frames, wraps
//   DBG_STATE  out  [1:0]  FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Parameter
//   BAUD_DIV   HCLK cycles per UART bit, 2..65535

module ahb_test_uart_reporter #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] ERRCOUNT,
    input  logic [7:0]  CHKCOUNT,
    input  logic        S_WRITE,
    input  logic        S_CHECK,
    input  logic        S_SUCCESS,
    input  logic        S_FAILED,
    output logic        UART_TX,
    output logic        BUSY,
    output logic [15:0] FRAME_CNT,
    output logic [1:0]  DBG_STATE
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [4:0]  LAST_BYTE = 5'd18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [15:0] r_baud_cnt;
    logic [3:0]  r_bit_cnt;
    logic [4:0]  r_byte_idx;
    logic [7:0]  r_snap_chk;
    logic [31:0] r_snap_err;
    logic [7:0]  r_snap_stat;
    logic        r_pending;
    logic        r_evt_d;
    logic [7:0]  r_chk_prev;
    logic        r_succ_prev;
    logic        r_fail_prev;
    logic [15:0] r_frame_cnt;
    logic        r_tx;
    logic        r_busy;

    logic        w_event;
    logic        w_go;
    logic        w_baud_end;
    logic        w_last_bit;
    logic        w_last_byte;
    logic        w_frame_start;
    logic        w_frame_done;
    logic [7:0]  w_status;
    logic [2:0]  w_nib_sel;
    logic [3:0]  w_err_nib;
    logic [7:0]  w_byte;
    logic [3:0]  w_bit_next;
    logic        w_tx_next;
    logic        w_busy_next;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign w_event = (CHKCOUNT != r_chk_prev)
                   | (S_SUCCESS & ~r_succ_prev)
                   | (S_FAILED  & ~r_fail_prev);

    // An event seen in IDLE is held for one cycle (r_evt_d) so the start bit
    // appears one edge after the event edge; events seen mid-frame go to
    // the one-deep pending flag instead.
    assign w_go        = r_evt_d | r_pending;
    assign w_baud_end  = (r_baud_cnt == BAUD_LAST);
    assign w_last_bit  = (r_bit_cnt == 4'd7);
    assign w_last_byte = (r_byte_idx == LAST_BYTE);

    assign w_frame_done  = (r_state == ST_STOP) && w_baud_end && w_last_byte;
    assign w_frame_start = ((r_state == ST_IDLE) && w_go)
                         || (w_frame_done && r_pending);

    always_comb begin
        w_status = 8'h2D;                       // '-'
        if (S_FAILED)       w_status = 8'h46;   // 'F'
        else if (S_SUCCESS) w_status = 8'h50;   // 'P'
        else if (S_CHECK)   w_status = 8'h4B;   // 'K'
        else if (S_WRITE)   w_status = 8'h57;   // 'W'
    end

    // Bytes 7..14 carry ERRCOUNT nibbles, most significant first.
    assign w_nib_sel = 3'(5'd14 - r_byte_idx);
    assign w_err_nib = r_snap_err[{w_nib_sel, 2'b00} +: 4];

    always_comb begin
        w_byte = 8'h0A;
        case (r_byte_idx)
            5'd0:  w_byte = 8'h43;                   // 'C'
            5'd1:  w_byte = 8'h3D;                   // '='
            5'd2:  w_byte = hex_char(r_snap_chk[7:4]);
            5'd3:  w_byte = hex_char(r_snap_chk[3:0]);
            5'd4:  w_byte = 8'h20;                   // ' '
            5'd5:  w_byte = 8'h45;                   // 'E'
            5'd6:  w_byte = 8'h3D;                   // '='
            5'd7, 5'd8, 5'd9, 5'd10,
            5'd11, 5'd12, 5'd13, 5'd14:
                   w_byte = hex_char(w_err_nib);
            5'd15: w_byte = 8'h20;                   // ' '
            5'd16: w_byte = r_snap_stat;
            5'd17: w_byte = 8'h0D;
            default: w_byte = 8'h0A;
        endcase
    end

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_go) w_state_next = ST_START;
            ST_START: if (w_baud_end) w_state_next = ST_DATA;
            ST_DATA:  if (w_baud_end && w_last_bit) w_state_next = ST_STOP;
            ST_STOP: begin
                if (w_baud_end) begin
                    if (!w_last_byte || r_pending) w_state_next = ST_START;
                    else                           w_state_next = ST_IDLE;
                end
            end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Output logic: computes next values of the registered line outputs
    // from the next state so UART_TX and BUSY come straight from flops.
    always_comb begin
        w_bit_next = 4'd0;
        if (r_state == ST_DATA)
            w_bit_next = w_baud_end ? (r_bit_cnt + 4'd1) : r_bit_cnt;

        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_byte[w_bit_next[2:0]];
            default:  w_tx_next = 1'b1;
        endcase

        w_busy_next = (w_state_next != ST_IDLE);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_baud_cnt  <= 16'd0;
            r_bit_cnt   <= 4'd0;
            r_byte_idx  <= 5'd0;
            r_snap_chk  <= 8'd0;
            r_snap_err  <= 32'd0;
            r_snap_stat <= 8'h2D;
            r_pending   <= 1'b0;
            r_evt_d     <= 1'b0;
            r_chk_prev  <= 8'd0;
            r_succ_prev <= 1'b0;
            r_fail_prev <= 1'b0;
            r_frame_cnt <= 16'd0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_chk_prev  <= CHKCOUNT;
            r_succ_prev <= S_SUCCESS;
            r_fail_prev <= S_FAILED;
            r_evt_d     <= w_event;
            r_tx        <= w_tx_next;
            r_busy      <= w_busy_next;
            r_bit_cnt   <= w_bit_next;

            if (r_state == ST_IDLE || w_baud_end) r_baud_cnt <= 16'd0;
            else                                   r_baud_cnt <= r_baud_cnt + 16'd1;

            // A mid-frame event wins over the clear on a back-to-back start,
            // so an event on the final stop edge still yields a follow-up.
            if (w_event && r_state != ST_IDLE) r_pending <= 1'b1;
            else if (w_frame_start)            r_pending <= 1'b0;

            if (w_frame_start) begin
                r_snap_chk  <= CHKCOUNT;
                r_snap_err  <= ERRCOUNT;
                r_snap_stat <= w_status;
                r_byte_idx  <= 5'd0;
            end else if (r_state == ST_STOP && w_baud_end && !w_last_byte) begin
                r_byte_idx  <= r_byte_idx + 5'd1;
            end

            if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign UART_TX   = r_tx;
    assign BUSY      = r_busy;
    assign FRAME_CNT = r_frame_cnt;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_ahb_test_uart_reporter.sv
// Directed testbench for ahb_test_uart_reporter with BAUD_DIV = 4.
// Decodes the UART line cycle by cycle and compares against hand-written
// expected lines.

module tb_ahb_test_uart_reporter;

    localparam int BD = 4;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] ERRCOUNT;
    logic [7:0]  CHKCOUNT;
    logic        S_WRITE, S_CHECK, S_SUCCESS, S_FAILED;
    logic        UART_TX, BUSY;
    logic [15:0] FRAME_CNT;
    logic [1:0]  DBG_STATE;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          busy_cnt;
    logic [7:0]  rx_buf [19];

    ahb_test_uart_reporter #(.BAUD_DIV(BD)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .ERRCOUNT  (ERRCOUNT),
        .CHKCOUNT  (CHKCOUNT),
        .S_WRITE   (S_WRITE),
        .S_CHECK   (S_CHECK),
        .S_SUCCESS (S_SUCCESS),
        .S_FAILED  (S_FAILED),
        .UART_TX   (UART_TX),
        .BUSY      (BUSY),
        .FRAME_CNT (FRAME_CNT),
        .DBG_STATE (DBG_STATE)
    );

    // Clock / reset block
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance negedge by negedge until the start bit is seen.
    task automatic wait_start(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (UART_TX === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge HCLK);
        end
    endtask

    // Called at the negedge in the first cycle of a start bit. Samples every
    // cycle of the 19 characters; any bit not held constant for BD cycles or
    // any bad start/stop bit counts into bad. Returns one negedge past the
    // last stop bit.
    task automatic recv_frame(output int bad);
        logic [9:0] bits;
        logic       v;
        bad      = 0;
        busy_cnt = 0;
        v        = 1'b0;
        for (int b = 0; b < 19; b++) begin
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < BD; c++) begin
                    if (BUSY === 1'b1) busy_cnt++;
                    if (c == 0) v = UART_TX;
                    else if (UART_TX !== v) bad++;
                    @(negedge HCLK);
                end
                bits[k] = v;
            end
            if (bits[0] !== 1'b0 || bits[9] !== 1'b1) bad++;
            rx_buf[b] = bits[8:1];
        end
    endtask

    // body: the 17 printable characters; CR LF are checked separately.
    task automatic check_frame(input string tag, input string body, input int bad);
        for (int i = 0; i < 17; i++)
            chk($sformatf("%s_char%0d", tag, i), {56'd0, rx_buf[i]}, {56'd0, body[i]});
        chk({tag, "_cr"}, {56'd0, rx_buf[17]}, 64'h0D);
        chk({tag, "_lf"}, {56'd0, rx_buf[18]}, 64'h0A);
        chk({tag, "_bit_timing"}, 64'(bad), 64'd0);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(190 * BD));
    endtask

    task automatic idle_watch(input int cycles, output int act);
        act = 0;
        repeat (cycles) begin
            @(negedge HCLK);
            if (UART_TX !== 1'b1 || BUSY !== 1'b0) act++;
        end
    endtask

    initial begin
        bit found;
        int bad;
        int act;

        HRESET = 1'b1; ERRCOUNT = 32'd0; CHKCOUNT = 8'd0;
        S_WRITE = 1'b0; S_CHECK = 1'b0; S_SUCCESS = 1'b0; S_FAILED = 1'b0;

        // Reset
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_tx", 64'(UART_TX), 64'd1);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_frame_cnt", 64'(FRAME_CNT), 64'd0);
        chk("rst_state", 64'(DBG_STATE), 64'd0);
        HRESET = 1'b0;
        idle_watch(1000, act);
        chk("rst_no_activity", 64'(act), 64'd0);

        // Single report with exact start latency
        ERRCOUNT = 32'h0000001F; S_CHECK = 1'b1; CHKCOUNT = 8'h01;
        @(negedge HCLK);
        chk("single_lat_tx_idle", 64'(UART_TX), 64'd1);
        chk("single_lat_busy_low", 64'(BUSY), 64'd0);
        @(negedge HCLK);
        chk("single_start_tx", 64'(UART_TX), 64'd0);
        chk("single_start_busy", 64'(BUSY), 64'd1);
        chk("single_start_state", 64'(DBG_STATE), 64'd1);
        recv_frame(bad);
        check_frame("single", "C=01 E=0000001F K", bad);
        chk("single_busy_end", 64'(BUSY), 64'd0);
        chk("single_frame_cnt", 64'(FRAME_CNT), 64'd1);
        idle_watch(20, act);
        chk("single_idle_after", 64'(act), 64'd0);

        // Coalescing: several events during one frame -> one follow-up
        CHKCOUNT = 8'h02;
        wait_start(10, found);
        chk("coal_a_found", 64'(found), 64'd1);
        fork
            recv_frame(bad);
            begin
                repeat (50) @(negedge HCLK);
                CHKCOUNT = 8'h09;
                repeat (100) @(negedge HCLK);
                CHKCOUNT = 8'h03;
                repeat (100) @(negedge HCLK);
                ERRCOUNT = 32'h00000005;
            end
        join
        check_frame("coal_a", "C=02 E=0000001F K", bad);
        chk("coal_no_gap_tx", 64'(UART_TX), 64'd0);
        chk("coal_no_gap_busy", 64'(BUSY), 64'd1);
        chk("coal_a_frame_cnt", 64'(FRAME_CNT), 64'd2);
        recv_frame(bad);
        check_frame("coal_b", "C=03 E=00000005 K", bad);
        chk("coal_b_frame_cnt", 64'(FRAME_CNT), 64'd3);
        idle_watch(100, act);
        chk("coal_single_followup", 64'(act), 64'd0);

        // Priority: F beats P beats W
        S_CHECK = 1'b0; S_WRITE = 1'b1; S_SUCCESS = 1'b1; S_FAILED = 1'b1;
        wait_start(10, found);
        chk("prio_f_found", 64'(found), 64'd1);
        recv_frame(bad);
        check_frame("prio_f", "C=03 E=00000005 F", bad);
        chk("prio_f_frame_cnt", 64'(FRAME_CNT), 64'd4);
        S_SUCCESS = 1'b0; S_FAILED = 1'b0;
        idle_watch(20, act);
        chk("prio_fall_no_event", 64'(act), 64'd0);

        // 'P' frame, with an event landing exactly on the final stop edge
        S_SUCCESS = 1'b1;
        wait_start(10, found);
        chk("prio_p_found", 64'(found), 64'd1);
        fork
            recv_frame(bad);
            begin
                repeat (190 * BD - 1) @(negedge HCLK);
                CHKCOUNT = 8'h0F;
            end
        join
        check_frame("prio_p", "C=03 E=00000005 P", bad);
        chk("edge_evt_end_tx", 64'(UART_TX), 64'd1);
        chk("edge_evt_end_busy", 64'(BUSY), 64'd0);
        chk("edge_evt_frame_cnt", 64'(FRAME_CNT), 64'd5);
        @(negedge HCLK);
        chk("edge_evt_start_tx", 64'(UART_TX), 64'd0);
        recv_frame(bad);
        check_frame("edge_evt", "C=0F E=00000005 P", bad);
        chk("edge_evt_frame_cnt2", 64'(FRAME_CNT), 64'd6);
        idle_watch(100, act);
        chk("edge_evt_single_followup", 64'(act), 64'd0);

        // Snapshot stability: ERRCOUNT churns every cycle mid-frame
        S_SUCCESS = 1'b0; S_WRITE = 1'b0; S_CHECK = 1'b1;
        ERRCOUNT = 32'h12345678; CHKCOUNT = 8'h4C;
        wait_start(10, found);
        chk("snap_found", 64'(found), 64'd1);
        fork
            recv_frame(bad);
            begin
                for (int i = 0; i < 750; i++) begin
                    ERRCOUNT = $urandom;
                    @(negedge HCLK);
                end
            end
        join
        check_frame("snap", "C=4C E=12345678 K", bad);
        chk("snap_frame_cnt", 64'(FRAME_CNT), 64'd7);

        // Reset mid-frame during character 7, then a fresh frame
        ERRCOUNT = 32'h0000BEEF; CHKCOUNT = 8'h5A;
        wait_start(10, found);
        chk("midrst_found", 64'(found), 64'd1);
        repeat (7 * 10 * BD + 10) @(negedge HCLK);
        chk("midrst_busy_before", 64'(BUSY), 64'd1);
        chk("midrst_cnt_before", 64'(FRAME_CNT), 64'd7);
        HRESET = 1'b1;
        @(negedge HCLK);
        chk("midrst_tx", 64'(UART_TX), 64'd1);
        chk("midrst_busy", 64'(BUSY), 64'd0);
        chk("midrst_frame_cnt", 64'(FRAME_CNT), 64'd0);
        chk("midrst_state", 64'(DBG_STATE), 64'd0);
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("midrst_lat_tx_idle", 64'(UART_TX), 64'd1);
        @(negedge HCLK);
        chk("midrst_restart_tx", 64'(UART_TX), 64'd0);
        recv_frame(bad);
        check_frame("midrst", "C=5A E=0000BEEF K", bad);
        chk("midrst_frame_cnt_after", 64'(FRAME_CNT), 64'd1);
        idle_watch(50, act);
        chk("midrst_idle_after", 64'(act), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
